// File: rtl/thirty_two_bit_alu.sv
// -----------------------------------------------------------------------------
// thirty_two_bit_alu
//
// Single-stage registered ALU. Operands and the op code are captured on every
// rising clock edge. The result and its three flags appear on the outputs one
// cycle later. There is no handshake, and a new operation is accepted on every
// cycle.
//
// Ports
//   clk       in   1      clock; all state changes on its rising edge
//   rst       in   1      synchronous, active-high reset
//   a         in   WIDTH  operand A, two's complement
//   b         in   WIDTH  operand B, two's complement
//   op        in   3      operation select
//                           000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//                           011/100/101 produce a zero result with no overflow
//   result    out  WIDTH  registered operation result
//   set       out  1      registered signed (a < b), for every op code
//   zero      out  1      registered flag, high when result is all zeros
//   overflow  out  1      registered signed overflow of the selected operation
// -----------------------------------------------------------------------------
module thirty_two_bit_alu #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic        [2:0]       op,
  output logic signed [WIDTH-1:0] result,
  output logic                    set,
  output logic                    zero,
  output logic                    overflow
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Signed overflow of a sum. It occurs when both addends share a sign and the
  // sum carries the other sign. Subtraction reuses this function with the
  // inverted subtrahend, because a - b is computed as a + ~b + 1.
  function automatic logic add_ovf(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y,
    input logic signed [WIDTH-1:0] s
  );
    add_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  // Sign of (a - b) corrected by the subtraction overflow gives the true signed
  // less-than. This holds even for extreme operands such as
  // 0x80000000 vs 0x7FFFFFFF.
  function automatic logic signed_lt(
    input logic signed [WIDTH-1:0] diff,
    input logic                    diff_ovf
  );
    signed_lt = diff[WIDTH-1] ^ diff_ovf;
  endfunction

  logic signed [WIDTH-1:0] b_inv;
  logic signed [WIDTH-1:0] sum;
  logic signed [WIDTH-1:0] diff;
  logic                    sum_ovf;
  logic                    diff_ovf;
  logic                    lt;

  logic signed [WIDTH-1:0] result_nxt;
  logic                    ovf_nxt;

  // Both adders are evaluated every cycle. The diff path also feeds the set
  // flag, whatever the selected op is, so the adders are not shared.
  always_comb begin
    b_inv    = ~b;
    sum      = a + b;
    diff     = a + b_inv + {{(WIDTH-1){1'b0}}, 1'b1};
    sum_ovf  = add_ovf(a, b, sum);
    diff_ovf = add_ovf(a, b_inv, diff);
    lt       = signed_lt(diff, diff_ovf);
  end

  always_comb begin
    result_nxt = '0;
    ovf_nxt    = 1'b0;
    unique case (op)
      OP_AND: result_nxt = a & b;
      OP_OR:  result_nxt = a | b;
      OP_ADD: begin
        result_nxt = sum;
        ovf_nxt    = sum_ovf;
      end
      OP_SUB: begin
        result_nxt = diff;
        ovf_nxt    = diff_ovf;
      end
      OP_SLT: begin
        result_nxt = {{(WIDTH-1){1'b0}}, lt};
        ovf_nxt    = diff_ovf;
      end
      default: begin
        result_nxt = '0;
        ovf_nxt    = 1'b0;
      end
    endcase
  end

  // ---- stage p1: output registers (all outputs come straight from here) ----
  logic signed [WIDTH-1:0] result_p1;
  logic                    set_p1;
  logic                    zero_p1;
  logic                    ovf_p1;

  // The zero flag is computed from result_nxt, the same value that loads
  // result_p1. It therefore always agrees with the registered result, and no
  // comparator sits behind the flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1 <= '0;
      set_p1    <= 1'b0;
      zero_p1   <= 1'b1;
      ovf_p1    <= 1'b0;
    end else begin
      result_p1 <= result_nxt;
      set_p1    <= lt;
      zero_p1   <= (result_nxt == '0);
      ovf_p1    <= ovf_nxt;
    end
  end

  assign result   = result_p1;
  assign set      = set_p1;
  assign zero     = zero_p1;
  assign overflow = ovf_p1;

endmodule

// File: tb/tb_thirty_two_bit_alu.sv
// -----------------------------------------------------------------------------
// tb_thirty_two_bit_alu
//
// Self-checking bench for thirty_two_bit_alu. It applies directed vectors with
// hand-computed results, checks the reset behaviour, and then compares against
// a reference model built from wide signed arithmetic over random vectors.
// -----------------------------------------------------------------------------
module tb_thirty_two_bit_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic [31:0] result;
  logic        set;
  logic        zero;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  thirty_two_bit_alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (result),
    .set      (set),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one operation, let it be captured, then sample one cycle later.
  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] vop);
    @(negedge clk);
    a  = va;
    b  = vb;
    op = vop;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic [2:0] vop, input logic [31:0] er, input logic es,
                          input logic ez, input logic eo);
    drive(va, vb, vop);
    check({tag, ".result"},   result,          er);
    check({tag, ".set"},      {31'b0, set},      {31'b0, es});
    check({tag, ".zero"},     {31'b0, zero},     {31'b0, ez});
    check({tag, ".overflow"}, {31'b0, overflow}, {31'b0, eo});
  endtask

  // Reference model. Signed quantities are evaluated in 64 bits, and overflow
  // is a range check on the exact value rather than a sign-bit trick.
  task automatic model(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] vop,
                       output logic [31:0] er, output logic es, output logic ez,
                       output logic eo);
    longint sa, sb, s, d;
    logic   d_out;
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    s  = sa + sb;
    d  = sa - sb;
    d_out = (d > 64'sd2147483647) || (d < -64'sd2147483648);
    es = (sa < sb);
    er = 32'h0;
    eo = 1'b0;
    case (vop)
      3'b000: er = va & vb;
      3'b001: er = va | vb;
      3'b010: begin
        er = s[31:0];
        eo = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        er = d[31:0];
        eo = d_out;
      end
      3'b111: begin
        er = es ? 32'h1 : 32'h0;
        eo = d_out;
      end
      default: begin
        er = 32'h0;
        eo = 1'b0;
      end
    endcase
    ez = (er == 32'h0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: rand_operand = 32'h8000_0000;
      1: rand_operand = 32'h7FFF_FFFF;
      2: rand_operand = 32'hFFFF_FFFF;
      3: rand_operand = 32'h0000_0000;
      default: rand_operand = $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb, er;
    logic [2:0]  rop;
    logic        es, ez, eo;

    rst = 1'b1;
    a   = 32'h0;
    b   = 32'h0;
    op  = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset.result",   result,            32'h0);
    check("reset.set",      {31'b0, set},      32'h0);
    check("reset.zero",     {31'b0, zero},     32'h1);
    check("reset.overflow", {31'b0, overflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    directed("or",      32'h0000_0043, 32'h8000_007F, 3'b001, 32'h8000_007F, 1'b0, 1'b0, 1'b0);
    directed("and",     32'h0000_0043, 32'h8000_007F, 3'b000, 32'h0000_0043, 1'b0, 1'b0, 1'b0);
    directed("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    directed("sub",     32'h0000_0043, 32'h8000_007F, 3'b110, 32'h7FFF_FFC4, 1'b0, 1'b0, 1'b0);
    directed("sub_eq",  32'h1234_5678, 32'h1234_5678, 3'b110, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    directed("slt_neg", 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    directed("slt_ext", 32'h8000_0000, 32'h7FFF_FFFF, 3'b111, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
    directed("slt_gt",  32'h7FFF_FFFF, 32'h8000_0000, 3'b111, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    directed("undef3",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    directed("undef4",  32'h8000_0000, 32'h0000_0001, 3'b100, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    directed("undef5",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b101, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    directed("add_neg", 32'h8000_0000, 32'h8000_0000, 3'b010, 32'h0000_0000, 1'b0, 1'b1, 1'b1);

    // Reset wins over an ADD presented in the same cycle. The outputs then hold
    // their reset values until the first edge with rst low.
    @(negedge clk);
    rst = 1'b1;
    a   = 32'h0000_0005;
    b   = 32'h0000_0007;
    op  = 3'b010;
    @(posedge clk);
    #1;
    check("rst_pri.result",   result,            32'h0);
    check("rst_pri.set",      {31'b0, set},      32'h0);
    check("rst_pri.zero",     {31'b0, zero},     32'h1);
    check("rst_pri.overflow", {31'b0, overflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst.result", result,       32'h0000_000C);
    check("post_rst.set",    {31'b0, set}, 32'h1);

    for (int i = 0; i < 10000; i++) begin
      ra  = rand_operand();
      rb  = rand_operand();
      rop = 3'($urandom_range(0, 7));
      model(ra, rb, rop, er, es, ez, eo);
      drive(ra, rb, rop);
      check("rand.result",   result,            er);
      check("rand.set",      {31'b0, set},      {31'b0, es});
      check("rand.zero",     {31'b0, zero},     {31'b0, ez});
      check("rand.overflow", {31'b0, overflow}, {31'b0, eo});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d expected more", checks);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
